pip_wb_receiver: RTL

- Consumer (slave) end of the pipeline writeback handshake. Sits between the execution-unit writeback output and the reorder-buffer result write port.
- Accepts writeback packets into a small FIFO skid buffer and encodes the six load/store fault flags into a single RISC-V exception cause.
- Presents one registered result per cycle to the ROB and honours ROB back-pressure, so no combinational ready path exists from ROB to execution unit.

---
 rtl/pip_wb_receiver.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pip_wb_receiver.sv
// pip_wb_receiver: consumer end of the writeback handshake.
// Buffers writeback packets in a small FIFO, folds the six load/store
// fault flags into one RISC-V mcause code at accept time, and presents
// the head entry to the ROB from registers only.
//
// Handshake rules:
// - Upstream: a packet transfers on a rising clock edge where wb_valid and
//   wb_ready are both high.
// - wb_ready depends only on registered occupancy. It never looks at
//   rob_busy or flush_i, so there is no combinational path from the ROB
//   back to the execution unit.
// - Downstream: rob_we marks a valid head entry. The entry retires on an
//   edge where rob_we is high and rob_busy is low.
module pip_wb_receiver #(
  parameter int XLEN   = 64,
  parameter int ITAG_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              flush_i,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [XLEN-1:0]   wb_data,
  input  logic [XLEN-1:0]   wb_csrdata,
  input  logic [XLEN-1:0]   wb_branchaddr,
  input  logic              wb_jump,
  input  logic [4:0]        wb_fflag,
  input  logic              wb_mmio,
  input  logic              wb_load_acc_flt,
  input  logic              wb_load_addr_mis,
  input  logic              wb_load_page_flt,
  input  logic              wb_store_acc_flt,
  input  logic              wb_store_addr_mis,
  input  logic              wb_store_page_flt,
  input  logic [ITAG_W-1:0] wb_itag,
  output logic              rob_we,
  input  logic              rob_busy,
  output logic [ITAG_W-1:0] rob_itag,
  output logic [XLEN-1:0]   rob_data,
  output logic [XLEN-1:0]   rob_csrdata,
  output logic [XLEN-1:0]   rob_branchaddr,
  output logic              rob_jump,
  output logic [4:0]        rob_fflag,
  output logic              rob_mmio,
  output logic              rob_exc,
  output logic [3:0]        rob_exc_code
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ITAG_W-1:0] itag;
    logic [XLEN-1:0]   data;
    logic [XLEN-1:0]   csrdata;
    logic [XLEN-1:0]   branchaddr;
    logic              jump;
    logic [4:0]        fflag;
    logic              mmio;
    logic              exc;
    logic [3:0]        exc_code;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             entry_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push;
  logic               pop;

  assign wb_ready = (count_q != CNT_W'(DEPTH));
  assign rob_we   = (count_q != '0);
  assign push     = wb_valid & wb_ready;
  assign pop      = rob_we & ~rob_busy;

  // Build the entry to store, encoding faults in mcause priority order.
  always_comb begin
    entry_d            = '0;
    entry_d.itag       = wb_itag;
    entry_d.data       = wb_data;
    entry_d.csrdata    = wb_csrdata;
    entry_d.branchaddr = wb_branchaddr;
    entry_d.jump       = wb_jump;
    entry_d.fflag      = wb_fflag;
    entry_d.mmio       = wb_mmio;
    entry_d.exc        = wb_load_addr_mis | wb_store_addr_mis |
                         wb_load_page_flt | wb_store_page_flt |
                         wb_load_acc_flt  | wb_store_acc_flt;
    if (wb_load_addr_mis)       entry_d.exc_code = 4'd4;
    else if (wb_store_addr_mis) entry_d.exc_code = 4'd6;
    else if (wb_load_page_flt)  entry_d.exc_code = 4'd13;
    else if (wb_store_page_flt) entry_d.exc_code = 4'd15;
    else if (wb_load_acc_flt)   entry_d.exc_code = 4'd5;
    else if (wb_store_acc_flt)  entry_d.exc_code = 4'd7;
    else                        entry_d.exc_code = 4'd0;
  end

  // Next-state for pointers and occupancy; flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
    end
  end

  // Control registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so idle outputs read zero, and a
  // handshake coinciding with a flush is not written.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush_i) begin
      mem_q[wr_ptr_q] <= entry_d;
    end
  end

  assign rob_itag       = mem_q[rd_ptr_q].itag;
  assign rob_data       = mem_q[rd_ptr_q].data;
  assign rob_csrdata    = mem_q[rd_ptr_q].csrdata;
  assign rob_branchaddr = mem_q[rd_ptr_q].branchaddr;
  assign rob_jump       = mem_q[rd_ptr_q].jump;
  assign rob_fflag      = mem_q[rd_ptr_q].fflag;
  assign rob_mmio       = mem_q[rd_ptr_q].mmio;
  assign rob_exc        = mem_q[rd_ptr_q].exc;
  assign rob_exc_code   = mem_q[rd_ptr_q].exc_code;

endmodule
